input_stage: RTL and testbench

Front end of the quantized linear-layer datapath. It collects one activation vector from the upstream stream, stores it in a register buffer, and computes the activation sum `ai` for zero-point correction. It then replays the vector once per output neuron to the MAC array while holding `ai` stable for the output stage's `Z_WEIGHTS*ai` term. It is the ingress counterpart of the requantizing output stage.

---
 rtl/input_stage.sv | 121 ++++++++++++
 tb/tb_input_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_stage.sv
// Ingress stage of the quantized linear layer: buffers one activation vector,
// sums it for zero-point correction, then replays it once per output neuron.
module input_stage #(
  parameter int PRECISION      = 8,
  parameter int N_INPUTS       = 16,
  parameter int N_PASSES       = 4,
  parameter int BIAS_PRECISION = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [PRECISION-1:0]                            in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [PRECISION-1:0]                            out_data,
  output logic                                            out_first,
  output logic                                            out_last,
  output logic [((N_PASSES > 1) ? $clog2(N_PASSES) : 1)-1:0] pass_idx,
  output logic [BIAS_PRECISION-1:0]                       ai,
  output logic                                            ai_valid
);

  localparam int IW = $clog2(N_INPUTS);
  localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_INPUTS - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(N_PASSES - 1);

  typedef enum logic {LOAD, REPLAY} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             wr_idx_q, wr_idx_d;
  logic [IW-1:0]             rd_idx_q, rd_idx_d;
  logic [PW-1:0]             pass_q, pass_d;
  logic [BIAS_PRECISION-1:0] ai_q, ai_d;
  logic [PRECISION-1:0]      buf_q [N_INPUTS];

  logic in_hs;
  logic out_hs;

  assign in_hs  = (state_q == LOAD) && in_valid;
  assign out_hs = (state_q == REPLAY) && out_ready;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    pass_d    = pass_q;
    ai_d      = ai_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    ai_valid  = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_hs) begin
          ai_d = ai_q + BIAS_PRECISION'(in_data);
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            pass_d   = '0;
            state_d  = REPLAY;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      REPLAY: begin
        out_valid = 1'b1;
        ai_valid  = 1'b1;
        out_data  = buf_q[rd_idx_q];
        out_first = (rd_idx_q == '0);
        out_last  = (rd_idx_q == LAST_IDX);
        if (out_hs) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            // Final element of the final pass frees the buffer for the next vector.
            if (pass_q == LAST_PASS) begin
              pass_d  = '0;
              ai_d    = '0;
              state_d = LOAD;
            end else begin
              pass_d = pass_q + PW'(1);
            end
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      pass_q   <= '0;
      ai_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      pass_q   <= pass_d;
      ai_q     <= ai_d;
    end
  end

  // Buffer is pure data storage; its contents are meaningless until reloaded.
  always_ff @(posedge clk) begin
    if (in_hs) buf_q[wr_idx_q] <= in_data;
  end

  assign pass_idx = pass_q;
  assign ai       = ai_q;

endmodule

// File: tb/tb_input_stage.sv
// Bench for input_stage: a 4-input/2-pass instance for the scenario and random
// tests, and a 16-input/4-pass instance for the full-scale sum.
`timescale 1ns/1ps
module tb_input_stage;
  localparam int N   = 4;
  localparam int NP  = 2;
  localparam int N16 = 16;
  localparam int NP16 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic        out_first, out_last, ai_valid;
  logic [0:0]  pass_idx;
  logic [31:0] ai;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_in_data, s_out_data;
  logic        s_out_first, s_out_last, s_ai_valid;
  logic [1:0]  s_pass_idx;
  logic [31:0] s_ai;

  int checks = 0;
  int failures = 0;
  logic [7:0] vec [N];

  always #5 clk = ~clk;

  input_stage #(.PRECISION(8), .N_INPUTS(N), .N_PASSES(NP), .BIAS_PRECISION(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .pass_idx(pass_idx),
    .ai(ai), .ai_valid(ai_valid));

  input_stage #(.PRECISION(8), .N_INPUTS(N16), .N_PASSES(NP16), .BIAS_PRECISION(32)) dut16 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_first(s_out_first), .out_last(s_out_last), .pass_idx(s_pass_idx),
    .ai(s_ai), .ai_valid(s_ai_valid));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_first_last got=%b%b exp=00", out_first, out_last); end
    checks++; if (ai !== 32'd0) begin failures++; $display("FAIL reset_ai got=%0d exp=0", ai); end
    checks++; if (ai_valid !== 1'b0) begin failures++; $display("FAIL reset_ai_valid got=%b exp=0", ai_valid); end
    checks++; if (pass_idx !== 1'b0) begin failures++; $display("FAIL reset_pass_idx got=%0d exp=0", pass_idx); end
    checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (s_in_ready !== 1'b1 || s_ai !== 32'd0) begin failures++; $display("FAIL reset16 got in_ready=%b ai=%0d exp 1/0", s_in_ready, s_ai); end
  endtask

  task automatic test_basic();
    vec = '{8'd10, 8'd20, 8'd30, 8'd255};
    for (int i = 0; i < N; i++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready i=%0d got=%b exp=1", i, in_ready); end
      in_valid = 1'b1; in_data = vec[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (ai !== 32'd315 || ai_valid !== 1'b1) begin failures++; $display("FAIL basic_ai got=%0d/%b exp=315/1", ai, ai_valid); end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_state got out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready); end
    for (int k = 0; k < N * NP; k++) begin
      checks++; if (out_data !== vec[k % N]) begin failures++; $display("FAIL basic_data k=%0d got=%0d exp=%0d", k, out_data, vec[k % N]); end
      checks++; if (out_first !== (k % N == 0) || out_last !== (k % N == N - 1)) begin failures++; $display("FAIL basic_marks k=%0d got=%b%b", k, out_first, out_last); end
      checks++; if (pass_idx !== 1'(k / N)) begin failures++; $display("FAIL basic_pass k=%0d got=%0d exp=%0d", k, pass_idx, k / N); end
      checks++; if (ai !== 32'd315) begin failures++; $display("FAIL basic_ai_hold k=%0d got=%0d exp=315", k, ai); end
      tick();
    end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_back_to_load got in_ready=%b out_valid=%b", in_ready, out_valid); end
    checks++; if (ai !== 32'd0 || ai_valid !== 1'b0) begin failures++; $display("FAIL basic_ai_clear got=%0d/%b exp=0/0", ai, ai_valid); end
  endtask

  task automatic test_backpressure();
    vec = '{8'd10, 8'd20, 8'd30, 8'd255};
    load_vec();
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_data !== 8'd30 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_data c=%0d got=%0d exp=30", c, out_data); end
      checks++; if (pass_idx !== 1'b0 || ai !== 32'd315) begin failures++; $display("FAIL bp_hold_pass_ai c=%0d got=%0d/%0d exp=0/315", c, pass_idx, ai); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < N * NP; k++) begin
      checks++; if (out_data !== vec[k % N] || pass_idx !== 1'(k / N)) begin failures++; $display("FAIL bp_resume k=%0d got=%0d/%0d exp=%0d/%0d", k, out_data, pass_idx, vec[k % N], k / N); end
      tick();
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_back_to_load got=%b exp=1", in_ready); end
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    int d;
    pat = 7'b1101001;
    d = 1;
    for (int p = 0; p < 7; p++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gaps_in_ready p=%0d got=%b exp=1", p, in_ready); end
      in_valid = pat[p];
      in_data  = pat[p] ? 8'(d) : 8'($urandom_range(100, 200));
      tick();
      if (pat[p]) d++;
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gaps_ready_drop got=%b exp=0", in_ready); end
    checks++; if (ai !== 32'd10 || ai_valid !== 1'b1) begin failures++; $display("FAIL gaps_ai got=%0d/%b exp=10/1", ai, ai_valid); end
    for (int k = 0; k < N * NP; k++) begin
      checks++; if (out_data !== 8'(k % N + 1)) begin failures++; $display("FAIL gaps_data k=%0d got=%0d exp=%0d", k, out_data, k % N + 1); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) vec[i] = 8'($urandom_range(0, 255));
    load_vec();
    out_ready = 1'b1;
    repeat (N + 1) tick();
    checks++; if (pass_idx !== 1'b1 || out_data !== vec[1]) begin failures++; $display("FAIL rstmid_position got=%0d/%0d exp=1/%0d", pass_idx, out_data, vec[1]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || ai_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b%b%b exp=100", in_ready, out_valid, ai_valid); end
    checks++; if (ai !== 32'd0 || pass_idx !== 1'b0 || out_data !== 8'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rstmid_values got ai=%0d pass=%0d data=%0d", ai, pass_idx, out_data); end
    vec = '{8'd5, 8'd5, 8'd5, 8'd5};
    load_vec();
    checks++; if (ai !== 32'd20) begin failures++; $display("FAIL rstmid_ai got=%0d exp=20", ai); end
    for (int k = 0; k < N * NP; k++) begin
      checks++; if (out_data !== 8'd5 || out_first !== (k % N == 0)) begin failures++; $display("FAIL rstmid_data k=%0d got=%0d exp=5", k, out_data); end
      tick();
    end
  endtask

  task automatic test_ignored();
    int sum;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      vec[i] = 8'($urandom_range(0, 255));
      sum += vec[i];
    end
    load_vec();
    in_valid = 1'b1; in_data = 8'd99;
    for (int k = 0; k < N * NP; k++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_in_ready k=%0d got=%b exp=0", k, in_ready); end
      checks++; if (out_data !== vec[k % N] || ai !== 32'(sum)) begin failures++; $display("FAIL ign_data k=%0d got=%0d/%0d exp=%0d/%0d", k, out_data, ai, vec[k % N], sum); end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || ai !== 32'd0) begin failures++; $display("FAIL ign_back_to_load got=%b/%0d exp=1/0", in_ready, ai); end
  endtask

  task automatic test_saturation();
    s_in_valid = 1'b1; s_in_data = 8'd255;
    repeat (N16) tick();
    s_in_valid = 1'b0;
    checks++; if (s_ai !== 32'd4080 || s_ai_valid !== 1'b1) begin failures++; $display("FAIL sat_ai got=%0d/%b exp=4080/1", s_ai, s_ai_valid); end
    s_out_ready = 1'b1;
    for (int k = 0; k < N16 * NP16; k++) begin
      checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'd255 || s_pass_idx !== 2'(k / N16)) begin failures++; $display("FAIL sat_replay k=%0d got=%0d/%0d exp=255/%0d", k, s_out_data, s_pass_idx, k / N16); end
      checks++; if (s_out_first !== (k % N16 == 0) || s_out_last !== (k % N16 == N16 - 1)) begin failures++; $display("FAIL sat_marks k=%0d got=%b%b", k, s_out_first, s_out_last); end
      tick();
    end
    checks++; if (s_in_ready !== 1'b1 || s_ai !== 32'd0) begin failures++; $display("FAIL sat_back_to_load got=%b/%0d exp=1/0", s_in_ready, s_ai); end
  endtask

  task automatic test_random();
    int sum, i, k, cyc;
    for (int it = 0; it < 20; it++) begin
      sum = 0;
      for (int j = 0; j < N; j++) begin
        vec[j] = 8'($urandom_range(0, 255));
        sum += vec[j];
      end
      i = 0;
      cyc = 0;
      while (i < N && cyc < 200) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rand_in_ready it=%0d got=%b exp=1", it, in_ready); end
        in_valid = 1'($urandom_range(0, 1));
        in_data  = in_valid ? vec[i] : 8'($urandom_range(0, 255));
        tick();
        if (in_valid) i++;
        cyc++;
      end
      in_valid = 1'b0;
      checks++; if (ai !== 32'(sum) || ai_valid !== 1'b1) begin failures++; $display("FAIL rand_ai it=%0d got=%0d exp=%0d", it, ai, sum); end
      k = 0;
      cyc = 0;
      while (k < N * NP && cyc < 200) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== vec[k % N] || out_first !== (k % N == 0) ||
            out_last !== (k % N == N - 1) || pass_idx !== 1'(k / N) || ai !== 32'(sum)) begin
          failures++;
          $display("FAIL rand_replay it=%0d k=%0d got data=%0d pass=%0d ai=%0d exp data=%0d pass=%0d ai=%0d",
                   it, k, out_data, pass_idx, ai, vec[k % N], k / N, sum);
        end
        out_ready = 1'($urandom_range(0, 1));
        tick();
        if (out_ready) k++;
        cyc++;
      end
      out_ready = 1'b1;
      checks++; if (k != N * NP) begin failures++; $display("FAIL rand_timeout it=%0d got=%0d exp=%0d elements", it, k, N * NP); end
      checks++; if (in_ready !== 1'b1 || ai !== 32'd0) begin failures++; $display("FAIL rand_back_to_load it=%0d got=%b/%0d exp=1/0", it, in_ready, ai); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_ignored();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
